// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 helpers shared by the CFB encryptor: S-box, xtime, MixColumns, rcon, FSM states
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  // Row is the high nibble, column the low nibble.
  localparam logic [7:0] SBOX_TBL [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 and 11..15 are zero so a 4-bit round number can index directly.
  localparam logic [7:0] RCON_TBL [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b[7:4], b[3:0]}];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return RCON_TBL[idx];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/cfb_e_if.sv
// rtl/cfb_e_if.sv - key/IV load and plaintext/ciphertext handshake bundle for cfb_e
interface cfb_e_if;
  logic [127:0] key;
  logic [127:0] iv;
  logic         iv_load;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  modport master (
    output key, iv, iv_load, in_valid, plaintext, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  key, iv, iv_load, in_valid, plaintext, out_ready,
    output in_ready, out_valid, ciphertext
  );
endinterface

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - combinational AES-128 next round key from (rk, rcon)
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_rk,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_rk_next
);
  logic [31:0] w_w0, w_w1, w_w2, w_w3, w_tmp, w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = i_rk[127:96];
  assign w_w1 = i_rk[95:64];
  assign w_w2 = i_rk[63:32];
  assign w_w3 = i_rk[31:0];

  // RotWord then SubWord on the last word, with rcon folded into the top byte.
  assign w_tmp = {sbox(w_w3[23:16]) ^ i_rcon, sbox(w_w3[15:8]), sbox(w_w3[7:0]), sbox(w_w3[31:24])};

  assign w_n0 = w_w0 ^ w_tmp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_rk_next = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/cfb_e.sv
// rtl/cfb_e.sv - AES-128 CFB-128 encryptor, one round per clock; CFB_E_BLK_CNT_EN adds a block counter
module cfb_e
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  cfb_e_if.slave      bus
`ifdef CFB_E_BLK_CNT_EN
  ,
  output logic [31:0] blk_cnt
`endif
);
  fsm_t         r_fsm;
  logic [3:0]   r_round;
  logic [127:0] r_chain, r_key, r_rk, r_st, r_pt, r_ct;
  logic         r_out_valid;

  logic [127:0] w_sr, w_mc, w_round, w_ct, w_ks_in, w_ks_next;
  logic [7:0]   w_ks_rcon;

  assign bus.in_ready   = rst_n && (r_fsm == ST_IDLE) && !bus.iv_load;
  assign bus.out_valid  = r_out_valid;
  assign bus.ciphertext = r_ct;

  // SubBytes + ShiftRows, then MixColumns; byte i sits at bits [127-8i -: 8], column-major.
  always_comb begin
    w_sr = '0;
    w_mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[127-8*(4*c+r) -: 8] = sbox(r_st[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
    end
  end

  assign w_round = ((r_round == 4'd10) ? w_sr : w_mc) ^ r_rk;
  assign w_ct    = w_round ^ r_pt;

  // In IDLE the schedule restarts from the stored key for the block about to be accepted.
  assign w_ks_in   = (r_fsm == ST_IDLE) ? r_key : r_rk;
  assign w_ks_rcon = (r_fsm == ST_IDLE) ? rcon(4'd1) : rcon(r_round + 4'd1);

  aes_key_step u_key_step (
    .i_rk      (w_ks_in),
    .i_rcon    (w_ks_rcon),
    .o_rk_next (w_ks_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm       <= ST_IDLE;
      r_round     <= '0;
      r_chain     <= '0;
      r_key       <= '0;
      r_rk        <= '0;
      r_st        <= '0;
      r_pt        <= '0;
      r_ct        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (bus.iv_load) begin
            r_chain <= bus.iv;
            r_key   <= bus.key;
            r_rk    <= bus.key;
          end else if (bus.in_valid) begin
            r_pt    <= bus.plaintext;
            r_st    <= r_chain ^ r_key;
            r_rk    <= w_ks_next;
            r_round <= 4'd1;
            r_fsm   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_st <= w_round;
          r_rk <= w_ks_next;
          if (r_round == 4'd10) begin
            r_round     <= '0;
            r_ct        <= w_ct;
            r_chain     <= w_ct;
            r_out_valid <= 1'b1;
            r_fsm       <= ST_DONE;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_fsm       <= ST_IDLE;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

`ifdef CFB_E_BLK_CNT_EN
  logic [31:0] r_blk_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
    end else if ((r_fsm == ST_IDLE) && bus.iv_load) begin
      r_blk_cnt <= '0;
    end else if (r_out_valid && bus.out_ready) begin
      r_blk_cnt <= r_blk_cnt + 32'd1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`endif
endmodule

// File: tb/tb_cfb_e.sv
// tb/tb_cfb_e.sv - self-checking bench for cfb_e against a byte-level AES/CFB reference model
module tb_cfb_e;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cfb_e_if bus ();
`ifdef CFB_E_BLK_CNT_EN
  logic [31:0] blk_cnt;
`endif

  cfb_e dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CFB_E_BLK_CNT_EN
    ,
    .blk_cnt (blk_cnt)
`endif
  );

  localparam logic [127:0] K_SP  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV_SP = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1 = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2 = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b;
  localparam logic [127:0] P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] C3 = 128'h26751f67a3cbb140b1808cf187a4f4df;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]   sbt [256];
  logic [127:0] m_key, m_chain;
  int           exp_cnt;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] blk);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rd == 10) s[4*c+r] = t[4*c+r];
          else s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                          ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] v);
    bus.key     = k;
    bus.iv      = v;
    bus.iv_load = 1'b1;
    tick();
    bus.iv_load = 1'b0;
    bus.key     = rnd128();
    bus.iv      = rnd128();
    m_key   = k;
    m_chain = v;
    exp_cnt = 0;
  endtask

  task automatic block(input string tag, input logic [127:0] pt, input int hold,
                       input bit disturb, output logic [127:0] got);
    logic [127:0] exp;
    int n;
    exp = aes_enc(m_key, m_chain) ^ pt;
    bus.plaintext = pt;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    n = 0;
    #1;
    while (!bus.in_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk({tag, " accept"}, 128'(bus.in_ready), 128'(1));
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      if (disturb && n == 2) begin
        bus.iv_load   = 1'b1;
        bus.in_valid  = 1'b1;
        bus.key       = rnd128();
        bus.iv        = rnd128();
        #1;
        chk({tag, " run in_ready"}, 128'(bus.in_ready), 128'(0));
      end
      if (disturb && n == 4) begin
        bus.iv_load  = 1'b0;
        bus.in_valid = 1'b0;
      end
      tick();
      n++;
    end
    bus.plaintext = rnd128();
    chk({tag, " latency"}, 128'(n), 128'(10));
    chk({tag, " ct"}, bus.ciphertext, exp);
    got = bus.ciphertext;
    for (int i = 0; i < hold; i++) begin
      chk({tag, " hold ct"}, bus.ciphertext, exp);
      chk({tag, " hold flags"}, 128'({bus.out_valid, bus.in_ready}), 128'(2'b10));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk({tag, " release flags"}, 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
    m_chain = exp;
    exp_cnt++;
  endtask

  initial begin
    logic [127:0] got;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    rst_n = 1'b0;
    bus.key = rnd128(); bus.iv = rnd128(); bus.iv_load = 1'b0;
    bus.in_valid = 1'b0; bus.plaintext = '0; bus.out_ready = 1'b1;
    m_key = '0; m_chain = '0; exp_cnt = 0;
    tick();
    tick();
    chk("reset in_ready", 128'(bus.in_ready), 128'(0));
    chk("reset out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset ct", bus.ciphertext, 128'(0));
    rst_n = 1'b1;
    #1;
    chk("idle in_ready", 128'(bus.in_ready), 128'(1));
    tick();

    block("no_iv", rnd128(), 0, 1'b0, got);

    bus.key = K_SP; bus.iv = IV_SP; bus.iv_load = 1'b1;
    bus.in_valid = 1'b1; bus.plaintext = P1;
    #1;
    chk("load+valid in_ready", 128'(bus.in_ready), 128'(0));
    tick();
    bus.iv_load = 1'b0;
    bus.key = rnd128(); bus.iv = rnd128();
    m_key = K_SP; m_chain = IV_SP; exp_cnt = 0;
`ifdef CFB_E_BLK_CNT_EN
    chk("cnt after load", 128'(blk_cnt), 128'(0));
`endif
    block("sp1", P1, 0, 1'b0, got);
    chk("sp1 vector", got, C1);
    block("sp2", P2, 0, 1'b0, got);
    chk("sp2 vector", got, C2);
    block("sp3", P3, 0, 1'b0, got);
    chk("sp3 vector", got, C3);
`ifdef CFB_E_BLK_CNT_EN
    chk("cnt three", 128'(blk_cnt), 128'(3));
`endif

    block("backpressure", rnd128(), 5, 1'b0, got);
    block("disturb", rnd128(), 0, 1'b1, got);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) load(rnd128(), rnd128());
      block("rand", rnd128(), int'($urandom_range(0, 3)), 1'b0, got);
`ifdef CFB_E_BLK_CNT_EN
      chk("rand cnt", 128'(blk_cnt), 128'(exp_cnt));
`endif
    end

    bus.plaintext = rnd128();
    bus.in_valid  = 1'b1;
    #1;
    chk("mid accept", 128'(bus.in_ready), 128'(1));
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst in_ready", 128'(bus.in_ready), 128'(0));
    chk("midrst out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst ct", bus.ciphertext, 128'(0));
`ifdef CFB_E_BLK_CNT_EN
    chk("midrst cnt", 128'(blk_cnt), 128'(0));
`endif
    rst_n = 1'b1;
    m_key = '0; m_chain = '0; exp_cnt = 0;
    #1;
    chk("post rst in_ready", 128'(bus.in_ready), 128'(1));
    tick();
    load(K_SP, IV_SP);
    block("rerun sp1", P1, 0, 1'b0, got);
    chk("rerun sp1 vector", got, C1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cfb_e.md
# cfb_e

Sequential AES-128 CFB-128 encryptor, the transmit-side counterpart of the combinational CFB decryptor. It runs one AES round per clock on the feedback register, XORs the keystream with the plaintext, and feeds each ciphertext block back as the next block's AES input. It sits between the plaintext source and the channel, behind a valid/ready handshake on both sides.

## Interface
- No parameters. Data width is fixed at 128 bits and the key schedule is fixed at AES-128.
- clk  in  1  single clock, all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- key  in  [128:1]  cipher key, sampled on `iv_load`
- iv  in  [128:1]  initialisation vector, sampled on `iv_load`
- iv_load  in  1  one-cycle pulse that starts a new chain; honoured only in IDLE
- in_valid  in  1  plaintext valid
- in_ready  out  1  block can accept plaintext
- plaintext  in  [128:1]  plaintext block
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts ciphertext
- ciphertext  out  [128:1]  ciphertext block, held stable while `out_valid`

## Operation
- Registers:
  - `chain` (feedback value)
  - `key_r`
  - `rk` (current round key, expanded on the fly)
  - `st` (AES state)
  - `pt_r`
  - `round` (4 bits)
  - `fsm`
- States are IDLE, RUN and DONE.
- IDLE:
  - `in_ready = 1` when `iv_load = 0`.
  - On `iv_load`, set `chain <= iv`, `key_r <= key` and `rk <= key`. `iv_load` has priority, so `in_ready` is 0 in that cycle.
  - On `in_valid && in_ready`, set `pt_r <= plaintext`, `st <= chain ^ key_r`, `rk <= expand(key_r, rcon1)`, `round <= 1`, then go to RUN.
- RUN:
  - Each cycle: `st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk`, `rk <= expand(rk, rcon[round+1])`, `round++`.
  - When `round == 10`, MixColumns is skipped.
  - In the `round == 10` cycle, also set `ciphertext <= final ^ pt_r` and `chain <= final ^ pt_r`, assert `out_valid`, and go to DONE.
- DONE:
  - `out_valid` and `ciphertext` are held until `out_ready`.
  - On `out_valid && out_ready`, clear `out_valid` and return to IDLE.
- Byte order: bits [128:121] are state byte 0, column-major, matching FIPS-197.
- Round function: ShiftRows and MixColumns are identical to the decryptor's forward cipher, so both ends compute the same keystream.
- `rk` is reloaded from `key_r` at each block accept. The key schedule never carries over from the previous block.
- Boundary conditions:
  - `iv_load` in RUN or DONE is ignored.
  - `in_valid` in RUN or DONE is not accepted. `plaintext` must be held by the source.
  - `key` and `iv` changes outside an `iv_load` cycle have no effect.
  - Before any `iv_load`, the chain is 0 and the key is 0, and the block still operates.
- Reset, applied in any state including mid-round, sets:
  - fsm = IDLE, `round` = 0
  - `chain`, `key_r`, `rk`, `st`, `pt_r` and `ciphertext` = 0
  - `out_valid` = 0
  - `in_ready` = 0 while `rst_n` is low

## Timing
- Accept at edge N sets `out_valid` high from edge N+10 (10 RUN cycles).
- If `out_ready` is already high, the handshake completes at edge N+11 and `in_ready` is high again in the cycle after that.
- Best-case throughput is one block per 12 cycles.
- The next block's AES input is the ciphertext of the previous block, available the cycle after DONE.
- The S-box is combinational: 16 parallel lookups for the state plus 4 for the key schedule, all in the same cycle.

## Configuration
- `CFB_E_BLK_CNT_EN` defined:
  - Adds output `blk_cnt [32:1]`.
  - It resets to 0 on `rst_n` low or `iv_load`.
  - It increments on each `out_valid && out_ready`, wrapping at 2^32-1 to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `aes_pkg`:
  - S-box function (4-bit row / 4-bit column lookup)
  - `xtime` and MixColumns helpers
  - `rcon` constant array (01,02,04,08,10,20,40,80,1b,36)
  - FSM state encoding
- Sub-module `aes_key_step`:
  - Combinational next-round-key from (rk, rcon): RotWord, SubWord, rcon XOR, then the word chain.
  - `cfb_e` instantiates it once.

## Test plan
- SP800-38A CFB128 block 1: `key=2b7e151628aed2a6abf7158809cf4f3c`, `iv=000102030405060708090a0b0c0d0e0f`, `pt=6bc1bee22e409f96e93d7e117393172a` -> `ct=3b3fd92eb72dad20333449f8e83cfb4a`, with `out_valid` exactly 10 cycles after accept.
- Chained blocks 2 and 3 with no new `iv_load`: `pt=ae2d8a571e03ac9c9eb76fac45af8e51` -> `c8a64537a0b3a93fcde3cdad9f1ce58b`; `pt=30c81c46a35ce411e5fbc1191a0a52ef` -> `26751f67a3cbb140b1808cf187a4f4df`.
- Backpressure: `out_ready` low for 5 cycles -> `out_valid` and `ct` held stable, `in_ready` low throughout, completes on the first `out_ready` high.
- `iv_load` and `in_valid` in the same IDLE cycle -> the IV is loaded, the plaintext is not accepted (`in_ready=0`), and it is accepted next cycle, giving the block-1 vector result.
- `rst_n` low in RUN at `round=5` -> next cycle all outputs 0 and fsm IDLE; re-run block 1 after `iv_load` and get the identical result.
- With `CFB_E_BLK_CNT_EN`: 3 blocks -> `blk_cnt=3`; after `iv_load` -> 0.
